// File: rtl/prbs15_pattern_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// prbs15_pattern_gen
//
// Transmit-side link-test byte source. One enable pulse starts a run that emits
// a captured 4-byte pattern n times (LSB byte first), followed by a 4-byte
// burst from a PRBS-15 LFSR (x^15+x^14+1) that is reseeded with 7FFF on
// every start. One byte per clock; Valid marks every generated byte.
//
// Ports
//   clk          rising-edge clock
//   arst_n       asynchronous active-low reset
//   enable       start request, honoured only while idle
//   n            number of pattern repetitions (0..31), captured at start
//   Pattern      pattern bytes, byte k = Pattern[8k+7:8k], captured at start
//   Valid        byte_out carries a generated byte this cycle (registered)
//   byte_out     generated byte, 0 while Valid=0 (registered)
//   dbg_state_o  current FSM state (0=IDLE, 1=PATT, 2=PRBS)
//
// Handshake: there is no back-pressure. enable is a request sampled on rising
// clk edges; it is accepted only in IDLE and ignored otherwise. Valid is a pure
// qualifier: whenever it is high, byte_out must be consumed that cycle.
// -----------------------------------------------------------------------------
module prbs15_pattern_gen #(
    parameter int patt_width   = 8,
    parameter int patt_num     = 4,
    parameter int REPEAT_TIMES = 5,
    parameter int PATT_W       = (patt_width << patt_num) / 4
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    enable,
    input  logic [REPEAT_TIMES-1:0] n,
    input  logic [PATT_W-1:0]       Pattern,
    output logic                    Valid,
    output logic [patt_width-1:0]   byte_out,
    output logic [1:0]              dbg_state_o
);

    localparam int                IDX_W     = $clog2(patt_num);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(patt_num - 1);
    localparam logic [14:0]       LFSR_SEED = 15'h7FFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PATT = 2'd1,
        PRBS = 2'd2
    } state_t;

    state_t                  state_q;
    logic [PATT_W-1:0]       patt_q;
    logic [REPEAT_TIMES-1:0] n_q;
    logic [IDX_W-1:0]        idx_q;
    logic [REPEAT_TIMES-1:0] rep_q;
    logic [14:0]             lfsr_q;
    logic                    valid_q;
    logic [patt_width-1:0]   byte_q;

    logic [patt_width-1:0]   patt_byte_d;
    logic [patt_width-1:0]   prbs_byte_d;
    logic [14:0]             lfsr_d;

    // Byte of the captured pattern selected by the byte index.
    always_comb begin
        patt_byte_d = '0;
        for (int k = 0; k < patt_num; k++) begin
            if (idx_q == IDX_W'(k)) begin
                patt_byte_d = patt_q[k*patt_width +: patt_width];
            end
        end
    end

    // Eight LFSR steps unrolled into one clock: step j's output bit (s[14]
    // before the shift) lands in byte bit j, so bit 0 is the oldest bit.
    always_comb begin
        lfsr_d      = lfsr_q;
        prbs_byte_d = '0;
        for (int j = 0; j < patt_width; j++) begin
            prbs_byte_d[j] = lfsr_d[14];
            lfsr_d         = {lfsr_d[13:0], lfsr_d[14] ^ lfsr_d[13]};
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            patt_q  <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            valid_q <= 1'b0;
            byte_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    byte_q  <= '0;
                    if (enable) begin
                        patt_q  <= Pattern;
                        n_q     <= n;
                        idx_q   <= '0;
                        rep_q   <= '0;
                        lfsr_q  <= LFSR_SEED;
                        state_q <= (n != '0) ? PATT : PRBS;
                    end
                end
                PATT: begin
                    valid_q <= 1'b1;
                    byte_q  <= patt_byte_d;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        rep_q <= rep_q + REPEAT_TIMES'(1);
                        // n_q is non-zero here: PATT is only entered with n != 0.
                        if (rep_q == n_q - REPEAT_TIMES'(1)) begin
                            state_q <= PRBS;
                        end
                    end
                end
                PRBS: begin
                    valid_q <= 1'b1;
                    byte_q  <= prbs_byte_d;
                    lfsr_q  <= lfsr_d;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    byte_q  <= '0;
                end
            endcase
        end
    end

    assign Valid       = valid_q;
    assign byte_out    = byte_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_prbs15_pattern_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_prbs15_pattern_gen
//
// Directed + randomized bench for prbs15_pattern_gen. Expected streams come
// from a reference model: the pattern bytes are listed per repetition, and the
// PRBS burst is derived from the output-bit recurrence of x^15+x^14+1
// (o[t] = o[t-15] ^ o[t-14], first 15 bits all ones for the 7FFF seed).
// Inputs change on falling edges; outputs are sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_prbs15_pattern_gen;

    localparam int W  = 8;
    localparam int NB = 4;
    localparam int RT = 5;
    localparam int PW = 32;

    // ---------------- clock / reset ----------------
    logic          clk    = 1'b0;
    logic          arst_n = 1'b1;
    logic          enable = 1'b0;
    logic [RT-1:0] n      = '0;
    logic [PW-1:0] Pattern = '0;
    logic          Valid;
    logic [W-1:0]  byte_out;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    prbs15_pattern_gen #(
        .patt_width  (W),
        .patt_num    (NB),
        .REPEAT_TIMES(RT),
        .PATT_W      (PW)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .enable     (enable),
        .n          (n),
        .Pattern    (Pattern),
        .Valid      (Valid),
        .byte_out   (byte_out),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: full expected byte stream of one run.
    task automatic build_expected(input logic [PW-1:0] pat, input int reps);
        logic         o [0:NB*W-1];
        logic [W-1:0] v;
        exp_q.delete();
        for (int r = 0; r < reps; r++) begin
            for (int k = 0; k < NB; k++) begin
                exp_q.push_back(pat[k*W +: W]);
            end
        end
        for (int t = 0; t < NB*W; t++) begin
            o[t] = (t < 15) ? 1'b1 : (o[t-15] ^ o[t-14]);
        end
        for (int b = 0; b < NB; b++) begin
            for (int j = 0; j < W; j++) begin
                v[j] = o[b*W + j];
            end
            exp_q.push_back(v);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge with the DUT due to be idle at the next rising
    // edge. Returns at the falling edge after the last expected byte, so a
    // following call lands its enable on the first idle edge.
    task automatic run(input logic [PW-1:0] pat, input int reps, input bit disturb,
                       input string tag);
        int len;
        build_expected(pat, reps);
        len     = exp_q.size();
        Pattern = pat;
        n       = RT'(reps);
        enable  = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        chk($sformatf("%s_lat_v", tag), Valid, 1'b0);
        chk($sformatf("%s_lat_b", tag), byte_out, '0);
        for (int i = 0; i < len; i++) begin
            if (disturb && i == 2) begin
                enable  = 1'b1;
                Pattern = $urandom;
                n       = RT'($urandom_range(1, 31));
            end
            if (disturb && i == 3) enable = 1'b0;
            @(negedge clk);
            chk($sformatf("%s_v%0d", tag, i), Valid, 1'b1);
            chk($sformatf("%s_b%0d", tag, i), byte_out, exp_q[i]);
        end
    endtask

    task automatic idle_check(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk($sformatf("%s_v%0d", tag, i), Valid, 1'b0);
            chk($sformatf("%s_b%0d", tag, i), byte_out, '0);
            chk($sformatf("%s_st%0d", tag, i), dbg_state, 2'd0);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed / random sequence ----------------
    initial begin
        logic [PW-1:0] pat;
        int            reps;

        // Reset held for 5 cycles.
        #1 arst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rst_v%0d", i), Valid, 1'b0);
            chk($sformatf("rst_b%0d", i), byte_out, '0);
        end
        arst_n = 1'b1;
        idle_check(3, "post_rst");

        // Basic run.
        run(32'h0D0C0B0A, 5, 1'b0, "basic");
        idle_check(2, "basic_end");

        // Back-to-back runs, second enable on the first idle edge.
        run(32'h0D0C0B04, 3, 1'b0, "b2b1");
        run(32'h0D000B04, 4, 1'b0, "b2b2");
        idle_check(1, "b2b_end");

        // n = 0: PRBS burst only.
        run(32'hAABBCCDD, 0, 1'b0, "n0");
        idle_check(1, "n0_end");

        // Boundary repetition counts.
        run(32'h01020304, 1, 1'b0, "n1");
        run(32'hF0E1D2C3, 31, 1'b0, "n31");
        idle_check(1, "n31_end");

        // Enable / Pattern / n changes during a run are ignored.
        run(32'h44332211, 4, 1'b1, "busy");
        idle_check(2, "busy_end");

        // Mid-run reset aborts asynchronously.
        Pattern = 32'h5A6B7C8D;
        n       = RT'(3);
        enable  = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_pre_v", Valid, 1'b1);
        #2 arst_n = 1'b0;
        #1;
        chk("mid_async_v", Valid, 1'b0);
        chk("mid_async_b", byte_out, '0);
        idle_check(2, "mid_hold");
        arst_n = 1'b1;
        idle_check(4, "mid_rel");
        run(32'h5A6B7C8D, 3, 1'b0, "mid_rerun");
        idle_check(1, "mid_end");

        // Randomized runs, some back-to-back, some with disturbance.
        for (int r = 0; r < 8; r++) begin
            pat  = $urandom;
            reps = $urandom_range(0, 31);
            run(pat, reps, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
            if ($urandom_range(0, 1) == 1) idle_check(1, $sformatf("rnd%0d_end", r));
        end
        idle_check(2, "final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
